// File: rtl/hazard_sequencer.sv
// Pipeline control for the 5-stage in-order core: load-use bubbles, branch flushes,
// memory-wait freeze with timeout, and saturating stall/flush performance counters.
module hazard_sequencer #(
  parameter int CNT_W        = 16,
  parameter int MAX_MEM_WAIT = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs2_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             pipe_hold_o,
  output logic [1:0]       state_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } state_t;

  localparam logic [7:0] MAX_WAIT = MAX_MEM_WAIT[7:0];

  state_t           r_state;
  state_t           w_next_state;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       w_next_wait_cnt;
  logic             r_timeout;
  logic             w_next_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_load_use;
  logic w_mem_stall;
  logic w_pc_write;
  logic w_if_id_write;
  logic w_if_id_flush;
  logic w_id_ex_bubble;
  logic w_pipe_hold;

  assign w_load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                      ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));
  assign w_mem_stall = mem_req_i && !mem_ready_i;

  always_comb begin
    w_pc_write      = 1'b1;
    w_if_id_write   = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_bubble  = 1'b0;
    w_pipe_hold     = 1'b0;
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    w_next_timeout  = r_timeout;

    case (r_state)
      ST_RUN: begin
        if (w_mem_stall) begin
          w_pc_write      = 1'b0;
          w_if_id_write   = 1'b0;
          w_pipe_hold     = 1'b1;
          w_next_state    = ST_MEM_WAIT;
          w_next_wait_cnt = 8'd1;
        end else if (w_load_use) begin
          // Branch in the same cycle is dropped: ID re-resolves it after the bubble.
          w_pc_write     = 1'b0;
          w_if_id_write  = 1'b0;
          w_id_ex_bubble = 1'b1;
        end else if (branch_taken_i) begin
          w_if_id_flush = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready_i) begin
          w_next_state    = ST_RUN;
          w_next_wait_cnt = 8'd0;
          if (w_load_use) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_bubble = 1'b1;
          end else if (branch_taken_i) begin
            w_if_id_flush = 1'b1;
          end
        end else begin
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_pipe_hold   = 1'b1;
          if (r_wait_cnt < MAX_WAIT) begin
            w_next_wait_cnt = r_wait_cnt + 8'd1;
          end else begin
            w_next_state   = ST_TIMEOUT;
            w_next_timeout = 1'b1;
          end
        end
      end
      ST_TIMEOUT: begin
        w_pc_write    = 1'b0;
        w_if_id_write = 1'b0;
        w_pipe_hold   = 1'b1;
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase

    // Reset overrides everything so the pipeline sees bubbles while it is held.
    if (rst_i) begin
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_if_id_flush  = 1'b0;
      w_id_ex_bubble = 1'b1;
      w_pipe_hold    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= 8'd0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
      r_timeout  <= w_next_timeout;
      if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_if_id_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign pc_write_o     = w_pc_write;
  assign if_id_write_o  = w_if_id_write;
  assign if_id_flush_o  = w_if_id_flush;
  assign id_ex_bubble_o = w_id_ex_bubble;
  assign pipe_hold_o    = w_pipe_hold;
  assign state_o        = r_state;
  assign mem_timeout_o  = r_timeout;
  assign stall_cnt_o    = r_stall_cnt;
  assign flush_cnt_o    = r_flush_cnt;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: three instances (default, short timeout,
// narrow counters) share one stimulus stream; each step checks hand-computed values.
module tb_hazard_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] id_rs1_i;
  logic [4:0] id_rs2_i;
  logic       id_uses_rs2_i;
  logic       ex_memread_i;
  logic [4:0] ex_rd_i;
  logic       branch_taken_i;
  logic       mem_req_i;
  logic       mem_ready_i;

  logic        m_pc_write, m_if_id_write, m_flush, m_bubble, m_hold, m_timeout;
  logic [1:0]  m_state;
  logic [15:0] m_stall_cnt, m_flush_cnt;

  logic        t_pc_write, t_if_id_write, t_flush, t_bubble, t_hold, t_timeout;
  logic [1:0]  t_state;
  logic [15:0] t_stall_cnt, t_flush_cnt;

  logic        s_pc_write, s_if_id_write, s_flush, s_bubble, s_hold, s_timeout;
  logic [1:0]  s_state;
  logic [2:0]  s_stall_cnt, s_flush_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  hazard_sequencer u_main (
    .clk_i(clk_i), .rst_i(rst_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_uses_rs2_i(id_uses_rs2_i), .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
    .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(m_pc_write), .if_id_write_o(m_if_id_write), .if_id_flush_o(m_flush),
    .id_ex_bubble_o(m_bubble), .pipe_hold_o(m_hold), .state_o(m_state),
    .mem_timeout_o(m_timeout), .stall_cnt_o(m_stall_cnt), .flush_cnt_o(m_flush_cnt)
  );

  hazard_sequencer #(.CNT_W(16), .MAX_MEM_WAIT(4)) u_to (
    .clk_i(clk_i), .rst_i(rst_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_uses_rs2_i(id_uses_rs2_i), .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
    .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(t_pc_write), .if_id_write_o(t_if_id_write), .if_id_flush_o(t_flush),
    .id_ex_bubble_o(t_bubble), .pipe_hold_o(t_hold), .state_o(t_state),
    .mem_timeout_o(t_timeout), .stall_cnt_o(t_stall_cnt), .flush_cnt_o(t_flush_cnt)
  );

  hazard_sequencer #(.CNT_W(3), .MAX_MEM_WAIT(15)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_uses_rs2_i(id_uses_rs2_i), .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
    .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(s_pc_write), .if_id_write_o(s_if_id_write), .if_id_flush_o(s_flush),
    .id_ex_bubble_o(s_bubble), .pipe_hold_o(s_hold), .state_o(s_state),
    .mem_timeout_o(s_timeout), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_idle();
    id_rs1_i       = 5'd0;
    id_rs2_i       = 5'd0;
    id_uses_rs2_i  = 1'b0;
    ex_memread_i   = 1'b0;
    ex_rd_i        = 5'd0;
    branch_taken_i = 1'b0;
    mem_req_i      = 1'b0;
    mem_ready_i    = 1'b0;
  endtask

  task automatic set_hazard(input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic uses_rs2);
    ex_memread_i  = 1'b1;
    ex_rd_i       = rd;
    id_rs1_i      = rs1;
    id_rs2_i      = rs2;
    id_uses_rs2_i = uses_rs2;
  endtask

  initial begin
    set_idle();
    rst_i = 1'b1;
    #1;
    chk("rst_pc_write", m_pc_write, 0);
    chk("rst_if_id_write", m_if_id_write, 0);
    chk("rst_bubble", m_bubble, 1);
    chk("rst_hold", m_hold, 0);
    chk("rst_state", m_state, 0);
    chk("rst_stall_cnt", m_stall_cnt, 0);
    chk("rst_timeout", m_timeout, 0);

    tick();
    rst_i = 1'b0;
    #1;
    chk("idle_pc_write", m_pc_write, 1);
    chk("idle_if_id_write", m_if_id_write, 1);
    chk("idle_bubble", m_bubble, 0);
    chk("idle_flush", m_flush, 0);

    // Load-use on rs1
    set_hazard(5'd5, 5'd5, 5'd0, 1'b0);
    #1;
    chk("lu_pc_write", m_pc_write, 0);
    chk("lu_if_id_write", m_if_id_write, 0);
    chk("lu_bubble", m_bubble, 1);
    tick();
    set_idle();
    #1;
    chk("lu_stall_cnt", m_stall_cnt, 1);
    chk("lu_bubble_gone", m_bubble, 0);

    // rd = x0 never stalls
    set_hazard(5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    chk("x0_pc_write", m_pc_write, 1);
    tick();
    chk("x0_stall_cnt", m_stall_cnt, 1);

    // rs2 gating
    set_hazard(5'd7, 5'd0, 5'd7, 1'b0);
    #1;
    chk("rs2_unused_pc_write", m_pc_write, 1);
    id_uses_rs2_i = 1'b1;
    #1;
    chk("rs2_used_pc_write", m_pc_write, 0);
    chk("rs2_used_bubble", m_bubble, 1);
    tick();
    set_idle();
    #1;
    chk("rs2_stall_cnt", m_stall_cnt, 2);

    // Taken branch, then branch masked by load-use
    branch_taken_i = 1'b1;
    #1;
    chk("br_flush", m_flush, 1);
    chk("br_pc_write", m_pc_write, 1);
    chk("br_bubble", m_bubble, 0);
    tick();
    chk("br_flush_cnt", m_flush_cnt, 1);
    set_hazard(5'd5, 5'd5, 5'd0, 1'b0);
    #1;
    chk("br_lu_flush", m_flush, 0);
    chk("br_lu_bubble", m_bubble, 1);
    chk("br_lu_pc_write", m_pc_write, 0);
    tick();
    set_idle();
    #1;
    chk("br_lu_stall_cnt", m_stall_cnt, 3);
    chk("br_lu_flush_cnt", m_flush_cnt, 1);

    // Memory wait: 3 frozen cycles, then ready
    mem_req_i   = 1'b1;
    mem_ready_i = 1'b0;
    #1;
    chk("mw1_hold", m_hold, 1);
    chk("mw1_state", m_state, 0);
    chk("mw1_pc_write", m_pc_write, 0);
    tick();
    chk("mw2_state", m_state, 1);
    chk("mw2_hold", m_hold, 1);
    tick();
    chk("mw3_state", m_state, 1);
    chk("mw3_hold", m_hold, 1);
    tick();
    mem_ready_i = 1'b1;
    #1;
    chk("mw4_state", m_state, 1);
    chk("mw4_hold", m_hold, 0);
    chk("mw4_pc_write", m_pc_write, 1);
    tick();
    set_idle();
    #1;
    chk("mw_done_state", m_state, 0);
    chk("mw_stall_cnt", m_stall_cnt, 6);
    chk("mw_to_inst_state", t_state, 0);

    // Timeout on the MAX_MEM_WAIT=4 instance
    mem_req_i   = 1'b1;
    mem_ready_i = 1'b0;
    repeat (4) tick();
    chk("to_edge4_state", t_state, 1);
    chk("to_edge4_flag", t_timeout, 0);
    tick();
    chk("to_edge5_state", t_state, 2);
    chk("to_edge5_flag", t_timeout, 1);
    chk("to_main_still_wait", m_state, 1);
    mem_ready_i = 1'b1;
    #1;
    chk("to_ready_pc_write", t_pc_write, 0);
    chk("to_ready_hold", t_hold, 1);
    chk("to_main_ready_pc_write", m_pc_write, 1);
    tick();
    chk("to_sticky_state", t_state, 2);
    chk("to_sticky_flag", t_timeout, 1);
    chk("to_main_back_run", m_state, 0);
    set_idle();
    rst_i = 1'b1;
    #1;
    chk("to_rst_state", t_state, 0);
    chk("to_rst_flag", t_timeout, 0);
    chk("to_rst_stall_cnt", t_stall_cnt, 0);
    chk("to_rst_flush_cnt", t_flush_cnt, 0);
    tick();
    rst_i = 1'b0;
    #1;
    chk("to_post_rst_pc_write", t_pc_write, 1);

    // Saturation on the CNT_W=3 instance
    set_hazard(5'd5, 5'd5, 5'd0, 1'b0);
    repeat (10) tick();
    chk("sat_stall_cnt", s_stall_cnt, 7);
    chk("sat_main_stall_cnt", m_stall_cnt, 10);
    chk("sat_pc_write", s_pc_write, 0);
    set_idle();
    tick();
    chk("sat_hold_at_max", s_stall_cnt, 7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
